prefetch_queue: RTL and testbench
=================================

Name: prefetch_queue

Overview:
Instruction prefetch queue between the memory byte bus and the x86cpu decode stage, in the manner of the 8086 bus interface unit. It issues sequential byte reads from a linear 20-bit fetch address whenever the bus is free and buffers up to DEPTH bytes. The decoder consumes the bytes in order. A flush (jump, call or interrupt) discards the buffered bytes and any reads in flight, then restarts fetching at a new address.

Parameters:
DEPTH, 6, queue capacity in bytes (2..15)
AW, 20, address width; addresses wrap modulo 2^AW
RD_LATENCY, 2, cycles from the mem_rd cycle to the cycle mem_i_data is valid (matches the registered RAM path)
RESET_ADDR, 20'hFFFF0, fetch address after reset (x86 reset vector)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  discard queue and in-flight reads, restart at flush_addr
flush_addr  in  AW  new fetch address, sampled when flush=1
mem_busy  in  1  CPU data cycle owns the bus this cycle; no fetch may be issued
mem_address  out  AW  read address, valid while mem_rd=1
mem_rd  out  1  registered read strobe, one byte per cycle
mem_i_data  in  8  read data, valid RD_LATENCY cycles after mem_rd
q_valid  out  1  head byte available
q_data  out  8  head byte
q_addr  out  AW  linear address of the head byte (the IP of the next opcode byte)
q_take  in  1  pop head byte this cycle; ignored when q_valid=0
q_count  out  4  bytes currently held

Behaviour:
- Reset, synchronous and active-high; takes priority over everything:
  - mem_rd=0, q_valid=0, q_count=0, in-flight tracker cleared.
  - fetch pointer fa=RESET_ADDR, q_addr=RESET_ADDR, mem_address=RESET_ADDR.
- Issue condition, evaluated every cycle: !reset & !flush & !mem_busy & (q_count + inflight) < DEPTH.
  - When met: mem_rd=1 and mem_address=fa in the next cycle, then fa<=fa+1 modulo 2^AW (FFFFF→00000).
  - Back-to-back reads are allowed, one per cycle.
- In-flight tracker: RD_LATENCY-deep valid shift register. Bit 0 is set on issue; the tail bit marks the cycle mem_i_data holds returning data. inflight = popcount.
- Return: when the tail bit is set, mem_i_data is written at the tail pointer at the end of that cycle. q_valid rises the next cycle.
- Pop: q_take & q_valid advances the head and sets q_addr<=q_addr+1 (wraps). Push and pop in the same cycle leave q_count unchanged.
- Full: the issue condition counts inflight, so the queue never overflows. A push into a full queue is impossible by construction; assertion required.
- Empty: q_take is ignored, q_data is don't-care, q_addr is still meaningful.
- Flush, priority over take, push and issue in the same cycle:
  - q_count<=0, all tracker bits cleared, so stale returns are dropped.
  - fa<=flush_addr, q_addr<=flush_addr, mem_rd<=0 that cycle.
  - Fetch resumes the following cycle if the bus is free.
- mem_busy mid-stream: the issue stalls, fa holds, and reads already in flight still complete.
- Pointers are mod-DEPTH counters; head and tail wrap from DEPTH-1 to 0.

Optional Feature:
PFQ_BYPASS_EN:
- Defined: when the queue is empty and a return arrives, q_valid=1 and q_data=mem_i_data combinationally in the same cycle.
  - q_take in that cycle consumes the byte without writing it; q_addr increments.
  - First-byte latency after a flush is RD_LATENCY+1 cycles.
- Undefined: purely registered outputs; first-byte latency is RD_LATENCY+2 cycles.

Decomposition:
- Package cpu_pkg: AW constant, RESET_VECTOR constant, address typedef addr_t, byte typedef byte_t.
- One sub-module, pfq_fifo: DEPTH-entry byte ring with push, pop, clear, count, head data.
- prefetch_queue owns fa, the in-flight tracker, the issue logic and the flush control.

Test Plan:
- Reset, no takes, mem_busy=0: reads issued at FFFF0..FFFF5; no seventh read; q_count=6; q_data=ram[FFFF0].
- Steady state, q_take held high, RAM = incrementing bytes: bytes pop in order. One byte per cycle after fill, no gaps, q_addr increments.
- Flush to 01000 while 2 reads are in flight: the stale returns never appear. The next q_valid byte is ram[01000] with q_addr=01000, RD_LATENCY+2 cycles after flush (RD_LATENCY+1 with PFQ_BYPASS_EN).
- Flush to FFFFE, then take 4 bytes: addresses FFFFE, FFFFF, 00000, 00001 with matching data.
- mem_busy high for 5 cycles mid-fill: no mem_rd during busy, the in-flight bytes still land, fetch resumes at the correct fa.
- flush and q_take asserted together with q_count=3: flush wins, q_count=0 next cycle, no pop side-effect on q_addr beyond flush_addr.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and types used by the instruction prefetch queue slice.
package cpu_pkg;
  localparam int unsigned AW = 20;

  typedef logic [AW-1:0] addr_t;
  typedef logic [7:0]    byte_t;

  localparam addr_t RESET_VECTOR = 20'hFFFF0;
endpackage

// File: rtl/prefetch_queue_if.sv
// Memory byte bus, flush control and decoder-side queue signals of the prefetch queue.
interface prefetch_queue_if #(
  parameter int unsigned AW = cpu_pkg::AW
);
  import cpu_pkg::*;

  logic          flush;
  logic [AW-1:0] flush_addr;
  logic          mem_busy;
  logic [AW-1:0] mem_address;
  logic          mem_rd;
  byte_t         mem_i_data;
  logic          q_valid;
  byte_t         q_data;
  logic [AW-1:0] q_addr;
  logic          q_take;
  logic [3:0]    q_count;

  // Environment side: CPU decode stage plus memory.
  modport master (
    output flush, flush_addr, mem_busy, mem_i_data, q_take,
    input  mem_address, mem_rd, q_valid, q_data, q_addr, q_count
  );

  // Prefetch queue side.
  modport slave (
    input  flush, flush_addr, mem_busy, mem_i_data, q_take,
    output mem_address, mem_rd, q_valid, q_data, q_addr, q_count
  );
endinterface

// File: rtl/prefetch_queue_fifo.sv
// pfq_fifo: DEPTH-entry byte ring buffer with push, pop, synchronous clear, count and head data.
module pfq_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  byte_t      wdata,
  output byte_t      rdata,
  output logic [3:0] count,
  output logic       empty
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  byte_t         mem_q [DEPTH];
  logic [PW-1:0] hd_q, hd_d, tl_q, tl_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          full;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == 4'(DEPTH));
  assign count  = cnt_q;
  assign rdata  = mem_q[hd_q];
  assign do_pop = pop && !empty;

  always_comb begin
    hd_d  = hd_q;
    tl_d  = tl_q;
    cnt_d = cnt_q;
    if (clr) begin
      hd_d  = '0;
      tl_d  = '0;
      cnt_d = '0;
    end else begin
      if (push)   tl_d = ptr_inc(tl_q);
      if (do_pop) hd_d = ptr_inc(hd_q);
      case ({push, do_pop})
        2'b10:   cnt_d = cnt_q + 4'd1;
        2'b01:   cnt_d = cnt_q - 4'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= '0;
    end else begin
      hd_q  <= hd_d;
      tl_q  <= tl_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr && push) mem_q[tl_q] <= wdata;
  end

  // Issue accounting reserves a slot for every outstanding read, so this cannot fire.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/prefetch_queue.sv
// 8086-style instruction prefetch queue: sequential byte fetch, in-order buffering, flush/restart.
// Optional macro PFQ_BYPASS_EN forwards a returning byte straight to the head when the queue is empty.
module prefetch_queue #(
  parameter int unsigned          DEPTH      = 6,
  parameter int unsigned          AW         = cpu_pkg::AW,
  parameter int unsigned          RD_LATENCY = 2,
  parameter logic [AW-1:0]        RESET_ADDR = cpu_pkg::RESET_VECTOR
) (
  input logic             clock,
  input logic             reset,
  prefetch_queue_if.slave bus
);
  import cpu_pkg::*;

  logic [AW-1:0]         fa_q, fa_d;
  logic [AW-1:0]         maddr_q, maddr_d;
  logic [AW-1:0]         qaddr_q, qaddr_d;
  logic                  rd_q;
  logic [RD_LATENCY-1:0] trk_q, trk_d;
  logic [4:0]            inflight, occupancy;
  logic                  issue, ret, byp, pop;
  logic                  f_push, f_pop, f_empty;
  logic [3:0]            f_count;
  byte_t                 f_rdata;

  pfq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .clr   (bus.flush),
    .push  (f_push),
    .pop   (f_pop),
    .wdata (bus.mem_i_data),
    .rdata (f_rdata),
    .count (f_count),
    .empty (f_empty)
  );

  assign ret = trk_q[RD_LATENCY-1];

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) inflight = inflight + 5'(trk_q[i]);
  end

  assign occupancy = 5'(f_count) + inflight;
  assign issue     = !bus.flush && !bus.mem_busy && (occupancy < 5'(DEPTH));

`ifdef PFQ_BYPASS_EN
  assign byp         = ret && f_empty;
  assign bus.q_valid = !f_empty || ret;
  assign bus.q_data  = f_empty ? bus.mem_i_data : f_rdata;
`else
  assign byp         = 1'b0;
  assign bus.q_valid = !f_empty;
  assign bus.q_data  = f_rdata;
`endif

  // A bypassed byte that is taken the same cycle never enters the ring.
  assign pop    = bus.q_take && bus.q_valid && !bus.flush;
  assign f_push = ret && !bus.flush && !(byp && bus.q_take);
  assign f_pop  = pop && !byp;

  always_comb begin
    trk_d[0] = issue;
    for (int unsigned i = 1; i < RD_LATENCY; i++) trk_d[i] = trk_q[i-1];
    if (bus.flush) trk_d = '0;

    maddr_d = issue ? fa_q : maddr_q;

    fa_d = fa_q;
    if (bus.flush)  fa_d = bus.flush_addr;
    else if (issue) fa_d = fa_q + AW'(1);

    qaddr_d = qaddr_q;
    if (bus.flush) qaddr_d = bus.flush_addr;
    else if (pop)  qaddr_d = qaddr_q + AW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q    <= 1'b0;
      trk_q   <= '0;
      fa_q    <= RESET_ADDR;
      maddr_q <= RESET_ADDR;
      qaddr_q <= RESET_ADDR;
    end else begin
      rd_q    <= issue;
      trk_q   <= trk_d;
      fa_q    <= fa_d;
      maddr_q <= maddr_d;
      qaddr_q <= qaddr_d;
    end
  end

  assign bus.mem_rd      = rd_q;
  assign bus.mem_address = maddr_q;
  assign bus.q_addr      = qaddr_q;
  assign bus.q_count     = f_count;
endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: vector table for fill/steady state, directed flush/busy sequences.
module tb_prefetch_queue;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 6;
`ifdef PFQ_BYPASS_EN
  localparam logic BYP = 1'b1;
  localparam int   FLUSH_LAT = 3;
`else
  localparam logic BYP = 1'b0;
  localparam int   FLUSH_LAT = 4;
`endif

  logic clock = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  prefetch_queue_if #(.AW(AW)) bus ();

  prefetch_queue #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .RD_LATENCY (2),
    .RESET_ADDR (RESET_VECTOR)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic byte_t ram(input addr_t a);
    return a[7:0] ^ {a[19:16], a[11:8]};
  endfunction

  // Registered RAM: data valid the cycle after the mem_rd cycle (two cycles counting the strobe).
  always @(posedge clock) bus.mem_i_data <= bus.mem_rd ? ram(bus.mem_address) : 8'hEE;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.flush_addr = '0;
    bus.mem_busy = 1'b0;
    bus.q_take = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       take;
    logic       rd;
    addr_t      maddr;
    logic       v;
    addr_t      qaddr;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic take, input logic rd, input addr_t maddr,
                              input logic v, input addr_t qaddr, input logic [3:0] cnt);
    vec_t r;
    r.take = take; r.rd = rd; r.maddr = maddr; r.v = v; r.qaddr = qaddr; r.cnt = cnt;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n;
    int    bad;
    addr_t a;
    logic [63:0] act_v, exp_v;

    // Fill from reset with no takes, then hold take high (cycle index = row index).
    tbl.push_back(mk(0, 0, 20'hFFFF0, 0,   20'hFFFF0, 0));
    tbl.push_back(mk(0, 1, 20'hFFFF0, 0,   20'hFFFF0, 0));
    tbl.push_back(mk(0, 1, 20'hFFFF1, BYP, 20'hFFFF0, 0));
    tbl.push_back(mk(0, 1, 20'hFFFF2, 1,   20'hFFFF0, 1));
    tbl.push_back(mk(0, 1, 20'hFFFF3, 1,   20'hFFFF0, 2));
    tbl.push_back(mk(0, 1, 20'hFFFF4, 1,   20'hFFFF0, 3));
    tbl.push_back(mk(0, 1, 20'hFFFF5, 1,   20'hFFFF0, 4));
    tbl.push_back(mk(0, 0, 20'hFFFF5, 1,   20'hFFFF0, 5));
    tbl.push_back(mk(0, 0, 20'hFFFF5, 1,   20'hFFFF0, 6));
    tbl.push_back(mk(0, 0, 20'hFFFF5, 1,   20'hFFFF0, 6));
    tbl.push_back(mk(1, 0, 20'hFFFF5, 1,   20'hFFFF0, 6));
    tbl.push_back(mk(1, 0, 20'hFFFF5, 1,   20'hFFFF1, 5));
    tbl.push_back(mk(1, 1, 20'hFFFF6, 1,   20'hFFFF2, 4));
    tbl.push_back(mk(1, 1, 20'hFFFF7, 1,   20'hFFFF3, 3));
    tbl.push_back(mk(1, 1, 20'hFFFF8, 1,   20'hFFFF4, 3));
    tbl.push_back(mk(1, 1, 20'hFFFF9, 1,   20'hFFFF5, 3));
    tbl.push_back(mk(1, 1, 20'hFFFFA, 1,   20'hFFFF6, 3));
    tbl.push_back(mk(1, 1, 20'hFFFFB, 1,   20'hFFFF7, 3));

    reset = 1'b1;
    bus.flush = 1'b0;
    bus.flush_addr = '0;
    bus.mem_busy = 1'b0;
    bus.q_take = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("reset_state", {bus.mem_rd, bus.q_valid, bus.q_count, bus.q_addr, bus.mem_address},
          {1'b0, 1'b0, 4'd0, 20'hFFFF0, 20'hFFFF0});
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) @(negedge clock);
      bus.q_take = tbl[i].take;
      #1;
      act_v = {bus.mem_rd, bus.mem_address, bus.q_valid, (tbl[i].v ? bus.q_data : 8'h00),
               bus.q_addr, bus.q_count};
      exp_v = {tbl[i].rd, tbl[i].maddr, tbl[i].v, (tbl[i].v ? ram(tbl[i].qaddr) : 8'h00),
               tbl[i].qaddr, tbl[i].cnt};
      check($sformatf("row%0d", i), act_v, exp_v);
    end
    bus.q_take = 1'b0;

    // Flush to 01000 while FFFF0 returns and FFFF1 is on the bus.
    do_reset();
    repeat (2) @(negedge clock);
    #1;
    check("b_pre_flush_rd", {bus.mem_rd, bus.mem_address}, {1'b1, 20'hFFFF1});
    bus.flush = 1'b1;
    bus.flush_addr = 20'h01000;
    @(negedge clock);
    bus.flush = 1'b0;
    #1;
    check("b_after_flush", {bus.q_valid, bus.q_count, bus.mem_rd, bus.q_addr},
          {1'b0, 4'd0, 1'b0, 20'h01000});
    n = 1;
    while (!bus.q_valid && n < 20) begin
      @(negedge clock);
      #1;
      n++;
      if (n == 2) check("b_refetch", {bus.mem_rd, bus.mem_address}, {1'b1, 20'h01000});
    end
    check("b_latency", 64'(n), 64'(FLUSH_LAT));
    check("b_head", {bus.q_addr, bus.q_data}, {20'h01000, ram(20'h01000)});

    // Flush near the top of the address space and take across the wrap.
    do_reset();
    bus.flush = 1'b1;
    bus.flush_addr = 20'hFFFFE;
    @(negedge clock);
    bus.flush = 1'b0;
    #1;
    n = 0;
    while (!bus.q_valid && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("c_first_valid", 64'(bus.q_valid), 64'(1));
    a = 20'hFFFFE;
    for (int i = 0; i < 4; i++) begin
      bus.q_take = 1'b1;
      check($sformatf("c_take%0d", i), {bus.q_valid, bus.q_addr, bus.q_data}, {1'b1, a, ram(a)});
      a = a + 20'd1;
      @(negedge clock);
      #1;
    end
    bus.q_take = 1'b0;
    check("c_qaddr_after", 64'(bus.q_addr), 64'(20'h00002));

    // mem_busy for five cycles right after the first two reads were issued.
    do_reset();
    bad = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clock);
      bus.mem_busy = (cyc >= 2 && cyc <= 6);
      #1;
      if (cyc >= 3 && cyc <= 7 && bus.mem_rd) bad++;
      if (cyc == 7)
        check("d_landed", {bus.q_count, bus.q_valid, bus.q_addr, bus.q_data},
              {4'd2, 1'b1, 20'hFFFF0, ram(20'hFFFF0)});
      if (cyc == 8) check("d_resume", {bus.mem_rd, bus.mem_address}, {1'b1, 20'hFFFF2});
      if (cyc == 9) check("d_resume2", {bus.mem_rd, bus.mem_address}, {1'b1, 20'hFFFF3});
    end
    check("d_no_rd_busy", 64'(bad), 64'(0));

    // flush and take together with three bytes held.
    do_reset();
    #1;
    n = 0;
    while (bus.q_count != 4'd3 && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("e_count3", {bus.q_count, bus.q_addr}, {4'd3, 20'hFFFF0});
    bus.q_take = 1'b1;
    bus.flush = 1'b1;
    bus.flush_addr = 20'h12345;
    @(negedge clock);
    bus.flush = 1'b0;
    bus.q_take = 1'b0;
    #1;
    check("e_flush_wins", {bus.q_count, bus.q_valid, bus.q_addr}, {4'd0, 1'b0, 20'h12345});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
